// File: rtl/tbox_pkg.sv
// tbox_pkg -- shared definitions for the tic-tac-toe style grid block.
//   game_state encodings : GS_PLAY, GS_XWIN, GS_OWIN, GS_DRAW
//   FSM state encoding   : state_t with ST_PLAY, ST_CHECK, ST_OVER
//   scan directions      : dir_t (horizontal, vertical, diagonal, anti-diagonal)
package tbox_pkg;

   localparam logic [1:0] GS_PLAY = 2'b00;
   localparam logic [1:0] GS_XWIN = 2'b01;
   localparam logic [1:0] GS_OWIN = 2'b10;
   localparam logic [1:0] GS_DRAW = 2'b11;

   // FSM states kept as plain constants so the encoding is stable on the
   // fsm_state debug port.
   typedef logic [1:0] state_t;
   localparam state_t ST_PLAY  = 2'd0;
   localparam state_t ST_CHECK = 2'd1;
   localparam state_t ST_OVER  = 2'd2;

   // Scan order is the enum order: H, V, D, A.
   typedef enum logic [1:0] {
      DIR_H = 2'd0,
      DIR_V = 2'd1,
      DIR_D = 2'd2,
      DIR_A = 2'd3
   } dir_t;

   localparam logic SYM_X = 1'b1;

endpackage

// File: rtl/tbox_line_scan.sv
// tbox_line_scan -- combinational evaluation of one scan offset.
// Given the scan direction, the signed offset along it, the placed cell
// (1-based row/col) and the board, decides whether the offset cell is on the
// board, occupied and carries the placed symbol, and returns the next run
// count (incremented on a hit, cleared otherwise).
//   dir      : scan direction
//   offset   : signed offset along the direction, -(K-1)..+(K-1)
//   prow/pcol: 1-based coordinates of the placed cell
//   psym     : placed symbol (1=X, 0=O)
//   valid    : cell occupied flags, index (row-1)*N+(col-1)
//   symbol   : cell symbols
//   run_cur  : current run count
//   run_next : run count after this offset
module tbox_line_scan
   import tbox_pkg::*;
#(
   parameter int N = 3,
   parameter int K = 3
) (
   input  dir_t                     dir,
   input  logic signed [3:0]        offset,
   input  logic [$clog2(N+1)-1:0]   prow,
   input  logic [$clog2(N+1)-1:0]   pcol,
   input  logic                     psym,
   input  logic [N*N-1:0]           valid,
   input  logic [N*N-1:0]           symbol,
   input  logic [$clog2(K+1)-1:0]   run_cur,
   output logic [$clog2(K+1)-1:0]   run_next
);

   localparam int IW  = $clog2(N*N);
   localparam int RCW = $clog2(K+1);

   logic signed [5:0] pr, pc, off, r, c;
   logic              on_board;
   logic              hit;
   logic [IW-1:0]     idx;
   int                lin;

   always_comb begin
      // 0-based placed coordinates and a sign-extended offset; 6 bits covers
      // -7..14 for every legal N and K.
      pr  = $signed({2'b00, 4'(prow)}) - 6'sd1;
      pc  = $signed({2'b00, 4'(pcol)}) - 6'sd1;
      off = {{2{offset[3]}}, offset};
      r   = pr;
      c   = pc;
      case (dir)
         DIR_H:   begin r = pr;       c = pc + off; end
         DIR_V:   begin r = pr + off; c = pc;       end
         DIR_D:   begin r = pr + off; c = pc + off; end
         DIR_A:   begin r = pr + off; c = pc - off; end
         default: begin r = pr;       c = pc;       end
      endcase
      on_board = (r >= 6'sd0) && (r < 6'(N)) && (c >= 6'sd0) && (c < 6'(N));
      lin      = int'(r) * N + int'(c);
      idx      = IW'(lin);
      // idx is only meaningful when on_board holds.
      hit      = on_board && valid[idx] && (symbol[idx] == psym);
      run_next = hit ? run_cur + RCW'(1) : '0;
   end

endmodule

// File: rtl/tbox_grid.sv
// tbox_grid -- N x N tic-tac-toe style board with K-in-a-row win detection.
// Moves are accepted in PLAY; each accepted move is followed by a CHECK phase
// that walks the four lines through the placed cell one offset per cycle.
//   clk, reset_n    : clock, synchronous active-low reset
//   new_game        : synchronous board clear (wins over move_req)
//   move_req/row/col: move request with 1-based coordinates
//   ready           : high only in PLAY
//   move_ack/err    : registered one-cycle response pulses
//   valid/symbol    : board state, index (row-1)*N+(col-1), 1=X 0=O
//   turn            : symbol of the next move (X first)
//   move_count      : occupied cell count
//   game_state      : 00 playing, 01 X wins, 10 O wins, 11 draw
//   fsm_state       : current FSM state (debug)
//
// Handshake: a move transfers on a rising edge where move_req=1 and ready=1;
// the outcome appears as exactly one of move_ack/move_err in the following
// cycle. move_req while ready=0 is ignored in CHECK; in OVER every request is
// answered with move_err. new_game in the same cycle drops the move silently.
module tbox_grid
   import tbox_pkg::*;
#(
   parameter  int N     = 3,
   parameter  int K     = 3,
   localparam int RW    = $clog2(N+1),
   localparam int CELLS = N*N,
   localparam int MCW   = $clog2(CELLS+1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             new_game,
   input  logic             move_req,
   input  logic [RW-1:0]    row,
   input  logic [RW-1:0]    col,
   output logic             ready,
   output logic             move_ack,
   output logic             move_err,
   output logic [CELLS-1:0] valid,
   output logic [CELLS-1:0] symbol,
   output logic             turn,
   output logic [MCW-1:0]   move_count,
   output logic [1:0]       game_state,
   output logic [1:0]       fsm_state
);

   localparam int IW  = $clog2(CELLS);
   localparam int RCW = $clog2(K+1);
   localparam logic signed [3:0] OFF_MIN = 4'(1 - K);
   localparam logic signed [3:0] OFF_MAX = 4'(K - 1);

   state_t            state_q;
   logic [CELLS-1:0]  valid_q, symbol_q;
   logic              turn_q;
   logic [MCW-1:0]    count_q;
   logic [1:0]        gs_q;
   logic              ack_q, err_q;
   logic [RW-1:0]     prow_q, pcol_q;
   logic              psym_q;
   dir_t              dir_q, dir_nx;
   logic signed [3:0] off_q;
   logic [RCW-1:0]    run_q, run_nx;

   logic              row_ok, col_ok, accept;
   logic [IW-1:0]     mv_idx;
   int                mv_lin;

   // Move decode: coordinates in range and target cell empty.
   always_comb begin
      row_ok = (row != '0) && (row <= RW'(N));
      col_ok = (col != '0) && (col <= RW'(N));
      mv_lin = (int'(row) - 1) * N + int'(col) - 1;
      mv_idx = IW'(mv_lin);
      accept = row_ok && col_ok && !valid_q[mv_idx];
   end

   always_comb begin
      dir_nx = DIR_H;
      case (dir_q)
         DIR_H:   dir_nx = DIR_V;
         DIR_V:   dir_nx = DIR_D;
         DIR_D:   dir_nx = DIR_A;
         default: dir_nx = DIR_H;
      endcase
   end

   tbox_line_scan #(.N(N), .K(K)) u_scan (
      .dir      (dir_q),
      .offset   (off_q),
      .prow     (prow_q),
      .pcol     (pcol_q),
      .psym     (psym_q),
      .valid    (valid_q),
      .symbol   (symbol_q),
      .run_cur  (run_q),
      .run_next (run_nx)
   );

   always_ff @(posedge clk) begin
      if (!reset_n || new_game) begin
         state_q  <= ST_PLAY;
         valid_q  <= '0;
         symbol_q <= '0;
         turn_q   <= SYM_X;
         count_q  <= '0;
         gs_q     <= GS_PLAY;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         prow_q   <= '0;
         pcol_q   <= '0;
         psym_q   <= 1'b0;
         dir_q    <= DIR_H;
         off_q    <= OFF_MIN;
         run_q    <= '0;
      end else begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         case (state_q)
            ST_PLAY: begin
               if (move_req) begin
                  if (accept) begin
                     valid_q[mv_idx]  <= 1'b1;
                     symbol_q[mv_idx] <= turn_q;
                     turn_q           <= ~turn_q;
                     count_q          <= count_q + MCW'(1);
                     ack_q            <= 1'b1;
                     prow_q           <= row;
                     pcol_q           <= col;
                     psym_q           <= turn_q;
                     dir_q            <= DIR_H;
                     off_q            <= OFF_MIN;
                     run_q            <= '0;
                     state_q          <= ST_CHECK;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            ST_CHECK: begin
               if (run_nx == RCW'(K)) begin
                  // Early exit as soon as the run reaches K.
                  gs_q    <= (psym_q == SYM_X) ? GS_XWIN : GS_OWIN;
                  state_q <= ST_OVER;
               end else if (off_q == OFF_MAX) begin
                  if (dir_q == DIR_A) begin
                     if (count_q == MCW'(CELLS)) begin
                        gs_q    <= GS_DRAW;
                        state_q <= ST_OVER;
                     end else begin
                        state_q <= ST_PLAY;
                     end
                  end else begin
                     // New direction: run restarts from zero.
                     dir_q <= dir_nx;
                     off_q <= OFF_MIN;
                     run_q <= '0;
                  end
               end else begin
                  off_q <= off_q + 4'sd1;
                  run_q <= run_nx;
               end
            end
            ST_OVER: begin
               if (move_req) err_q <= 1'b1;
            end
            default: state_q <= ST_PLAY;
         endcase
      end
   end

   assign ready      = (state_q == ST_PLAY);
   assign move_ack   = ack_q;
   assign move_err   = err_q;
   assign valid      = valid_q;
   assign symbol     = symbol_q;
   assign turn       = turn_q;
   assign move_count = count_q;
   assign game_state = gs_q;
   assign fsm_state  = state_q;

endmodule

// File: tb/tb_tbox_grid.sv
// tb_tbox_grid -- bench for tbox_grid with a 3x3/K=3 instance (a) and a
// 5x5/K=4 instance (b). Expected move responses are queued when a move is
// driven and popped by a monitor when move_ack/move_err appear.
module tb_tbox_grid;
   import tbox_pkg::*;

   localparam int NA = 3, KA = 3, NB = 5, KB = 4;
   localparam int RWA = $clog2(NA+1), RWB = $clog2(NB+1);
   localparam int CA = NA*NA, CB = NB*NB;
   localparam int MWA = $clog2(CA+1), MWB = $clog2(CB+1);
   localparam logic [1:0] R_ACK = 2'd1, R_ERR = 2'd2;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic           new_game_a = 1'b0, move_req_a = 1'b0;
   logic [RWA-1:0] row_a = '0, col_a = '0;
   logic           ready_a, ack_a, err_a, turn_a;
   logic [CA-1:0]  valid_a, symbol_a;
   logic [MWA-1:0] cnt_a;
   logic [1:0]     gs_a, fsm_a;

   logic           new_game_b = 1'b0, move_req_b = 1'b0;
   logic [RWB-1:0] row_b = '0, col_b = '0;
   logic           ready_b, ack_b, err_b, turn_b;
   logic [CB-1:0]  valid_b, symbol_b;
   logic [MWB-1:0] cnt_b;
   logic [1:0]     gs_b, fsm_b;

   int n_checks = 0;
   int n_fail   = 0;

   logic [1:0] exp_q_a[$];
   logic [1:0] exp_q_b[$];
   logic [1:0] got_a, want_a, got_b, want_b;

   // Reference board models.
   logic [CA-1:0] m_valid_a = '0, m_sym_a = '0;
   logic          m_turn_a = 1'b1;
   int            m_cnt_a = 0;
   logic [CB-1:0] m_valid_b = '0, m_sym_b = '0;
   logic          m_turn_b = 1'b1;
   int            m_cnt_b = 0;

   tbox_grid #(.N(NA), .K(KA)) dut_a (
      .clk(clk), .reset_n(reset_n), .new_game(new_game_a), .move_req(move_req_a),
      .row(row_a), .col(col_a), .ready(ready_a), .move_ack(ack_a), .move_err(err_a),
      .valid(valid_a), .symbol(symbol_a), .turn(turn_a), .move_count(cnt_a),
      .game_state(gs_a), .fsm_state(fsm_a)
   );

   tbox_grid #(.N(NB), .K(KB)) dut_b (
      .clk(clk), .reset_n(reset_n), .new_game(new_game_b), .move_req(move_req_b),
      .row(row_b), .col(col_b), .ready(ready_b), .move_ack(ack_b), .move_err(err_b),
      .valid(valid_b), .symbol(symbol_b), .turn(turn_b), .move_count(cnt_b),
      .game_state(gs_b), .fsm_state(fsm_b)
   );

   // Scoreboard monitors: every response pulse must match the queue head.
   always @(negedge clk) begin
      if (ack_a || err_a) begin
         n_checks++;
         got_a = {err_a, ack_a};
         if (exp_q_a.size() == 0) begin
            n_fail++;
            $display("FAIL resp_a: got {err,ack}=%b, required no response", got_a);
         end else begin
            want_a = exp_q_a.pop_front();
            if (got_a !== want_a) begin
               n_fail++;
               $display("FAIL resp_a: got {err,ack}=%b, required %b", got_a, want_a);
            end
         end
      end
      if (ack_b || err_b) begin
         n_checks++;
         got_b = {err_b, ack_b};
         if (exp_q_b.size() == 0) begin
            n_fail++;
            $display("FAIL resp_b: got {err,ack}=%b, required no response", got_b);
         end else begin
            want_b = exp_q_b.pop_front();
            if (got_b !== want_b) begin
               n_fail++;
               $display("FAIL resp_b: got {err,ack}=%b, required %b", got_b, want_b);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   // Drives one move, then counts cycles with ready low until the block
   // returns to PLAY or the game ends; checks response and board model.
   task automatic move_a(input int r, input int c, input logic [1:0] exp, output int low);
      int idx;
      exp_q_a.push_back(exp);
      @(posedge clk); #1;
      move_req_a = 1'b1; row_a = RWA'(r); col_a = RWA'(c);
      @(posedge clk); #1;
      move_req_a = 1'b0;
      if (exp == R_ACK) begin
         idx = (r - 1) * NA + (c - 1);
         m_valid_a[idx] = 1'b1;
         m_sym_a[idx]   = m_turn_a;
         m_turn_a       = ~m_turn_a;
         m_cnt_a++;
      end
      low = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (ready_a || gs_a != GS_PLAY) break;
         low++;
      end
      #1;
      n_checks++;
      if (exp_q_a.size() != 0) begin
         n_fail++;
         $display("FAIL pending_a (%0d,%0d): got %0d outstanding responses, required 0", r, c, exp_q_a.size());
         exp_q_a.delete();
      end
      n_checks++;
      if ({valid_a, symbol_a, turn_a, cnt_a} !== {m_valid_a, m_sym_a, m_turn_a, MWA'(m_cnt_a)}) begin
         n_fail++;
         $display("FAIL board_a (%0d,%0d): got v=%h s=%h t=%b n=%0d, required v=%h s=%h t=%b n=%0d",
                  r, c, valid_a, symbol_a, turn_a, cnt_a, m_valid_a, m_sym_a, m_turn_a, m_cnt_a);
      end
   endtask

   task automatic move_b(input int r, input int c, input logic [1:0] exp, output int low);
      int idx;
      exp_q_b.push_back(exp);
      @(posedge clk); #1;
      move_req_b = 1'b1; row_b = RWB'(r); col_b = RWB'(c);
      @(posedge clk); #1;
      move_req_b = 1'b0;
      if (exp == R_ACK) begin
         idx = (r - 1) * NB + (c - 1);
         m_valid_b[idx] = 1'b1;
         m_sym_b[idx]   = m_turn_b;
         m_turn_b       = ~m_turn_b;
         m_cnt_b++;
      end
      low = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (ready_b || gs_b != GS_PLAY) break;
         low++;
      end
      #1;
      n_checks++;
      if (exp_q_b.size() != 0) begin
         n_fail++;
         $display("FAIL pending_b (%0d,%0d): got %0d outstanding responses, required 0", r, c, exp_q_b.size());
         exp_q_b.delete();
      end
      n_checks++;
      if ({valid_b, symbol_b, turn_b, cnt_b} !== {m_valid_b, m_sym_b, m_turn_b, MWB'(m_cnt_b)}) begin
         n_fail++;
         $display("FAIL board_b (%0d,%0d): got v=%h s=%h t=%b n=%0d, required v=%h s=%h t=%b n=%0d",
                  r, c, valid_b, symbol_b, turn_b, cnt_b, m_valid_b, m_sym_b, m_turn_b, m_cnt_b);
      end
   endtask

   task automatic new_game_pulse_a();
      @(posedge clk); #1;
      new_game_a = 1'b1;
      @(posedge clk); #1;
      new_game_a = 1'b0;
      m_valid_a = '0; m_sym_a = '0; m_turn_a = 1'b1; m_cnt_a = 0;
   endtask

   task automatic new_game_pulse_b();
      @(posedge clk); #1;
      new_game_b = 1'b1;
      @(posedge clk); #1;
      new_game_b = 1'b0;
      m_valid_b = '0; m_sym_b = '0; m_turn_b = 1'b1; m_cnt_b = 0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({valid_a, symbol_a, turn_a, cnt_a, gs_a, ack_a, err_a, ready_a, fsm_a} !==
          {{CA{1'b0}}, {CA{1'b0}}, 1'b1, MWA'(0), GS_PLAY, 1'b0, 1'b0, 1'b1, ST_PLAY}) begin
         n_fail++;
         $display("FAIL reset_a: got v=%h s=%h t=%b n=%0d gs=%b ack=%b err=%b rdy=%b st=%0d, required zeros t=1 rdy=1 st=0",
                  valid_a, symbol_a, turn_a, cnt_a, gs_a, ack_a, err_a, ready_a, fsm_a);
      end
      n_checks++;
      if ({valid_b, symbol_b, turn_b, cnt_b, gs_b, ack_b, err_b, ready_b, fsm_b} !==
          {{CB{1'b0}}, {CB{1'b0}}, 1'b1, MWB'(0), GS_PLAY, 1'b0, 1'b0, 1'b1, ST_PLAY}) begin
         n_fail++;
         $display("FAIL reset_b: got v=%h t=%b n=%0d gs=%b rdy=%b st=%0d, required zeros t=1 rdy=1 st=0",
                  valid_b, turn_b, cnt_b, gs_b, ready_b, fsm_b);
      end
   endtask

   task automatic test_row_win();
      int low;
      int wr[5] = '{1, 2, 1, 2, 1};
      int wc[5] = '{1, 1, 2, 2, 3};
      new_game_pulse_a();
      for (int i = 0; i < 5; i++) begin
         move_a(wr[i], wc[i], R_ACK, low);
         n_checks++;
         if (i < 4 && low != 4 * (2 * KA - 1)) begin
            n_fail++;
            $display("FAIL check_len_row move %0d: got %0d low cycles, required %0d", i + 1, low, 4 * (2 * KA - 1));
         end else if (i == 4 && low > 20) begin
            n_fail++;
            $display("FAIL win_latency_row: got %0d cycles, required <= 20", low);
         end
      end
      n_checks++;
      if (gs_a !== GS_XWIN || fsm_a !== ST_OVER) begin
         n_fail++;
         $display("FAIL row_win_state: got gs=%b st=%0d, required gs=01 st=%0d", gs_a, fsm_a, ST_OVER);
      end
      move_a(3, 3, R_ERR, low);
      n_checks++;
      if (gs_a !== GS_XWIN) begin
         n_fail++;
         $display("FAIL over_hold: got gs=%b, required 01", gs_a);
      end
   endtask

   task automatic test_occupied();
      int low;
      new_game_pulse_a();
      move_a(2, 2, R_ACK, low);
      move_a(2, 2, R_ERR, low);
      n_checks++;
      if (turn_a !== 1'b0 || cnt_a !== MWA'(1)) begin
         n_fail++;
         $display("FAIL occupied_hold: got turn=%b count=%0d, required turn=0 count=1", turn_a, cnt_a);
      end
      move_a(0, 1, R_ERR, low);
      move_a(1, 0, R_ERR, low);
      move_a(1, 1, R_ACK, low);
   endtask

   task automatic test_draw();
      int low;
      int dr[9] = '{1, 1, 1, 2, 2, 2, 3, 3, 3};
      int dc[9] = '{1, 2, 3, 2, 1, 3, 2, 1, 3};
      new_game_pulse_a();
      for (int i = 0; i < 9; i++) begin
         move_a(dr[i], dc[i], R_ACK, low);
         n_checks++;
         if (low != 20) begin
            n_fail++;
            $display("FAIL draw_check_len move %0d: got %0d low cycles, required 20", i + 1, low);
         end
      end
      n_checks++;
      if (gs_a !== GS_DRAW || cnt_a !== MWA'(9) || ready_a !== 1'b0) begin
         n_fail++;
         $display("FAIL draw_state: got gs=%b count=%0d ready=%b, required gs=11 count=9 ready=0", gs_a, cnt_a, ready_a);
      end
   endtask

   task automatic test_anti_diag();
      int low;
      int ar[10] = '{1, 1, 5, 2, 0, 6, 3, 3, 5, 4};
      int ac[10] = '{1, 4, 5, 3, 1, 1, 5, 2, 2, 1};
      logic [1:0] ae[10] = '{R_ACK, R_ACK, R_ACK, R_ACK, R_ERR, R_ERR, R_ACK, R_ACK, R_ACK, R_ACK};
      new_game_pulse_b();
      for (int i = 0; i < 10; i++) begin
         move_b(ar[i], ac[i], ae[i], low);
         n_checks++;
         if (i < 9 && ae[i] == R_ACK && low != 4 * (2 * KB - 1)) begin
            n_fail++;
            $display("FAIL check_len_b move %0d: got %0d low cycles, required %0d", i + 1, low, 4 * (2 * KB - 1));
         end else if (ae[i] == R_ERR && low != 0) begin
            n_fail++;
            $display("FAIL err_ready_b move %0d: got %0d low cycles, required 0", i + 1, low);
         end else if (i == 9 && low > 4 * (2 * KB - 1)) begin
            n_fail++;
            $display("FAIL win_latency_b: got %0d cycles, required <= %0d", low, 4 * (2 * KB - 1));
         end
      end
      n_checks++;
      if (gs_b !== GS_OWIN || fsm_b !== ST_OVER) begin
         n_fail++;
         $display("FAIL anti_diag_state: got gs=%b st=%0d, required gs=10 st=%0d", gs_b, fsm_b, ST_OVER);
      end
      move_b(5, 1, R_ERR, low);
   endtask

   task automatic test_collision();
      int low;
      new_game_pulse_a();
      move_a(1, 1, R_ACK, low);
      @(posedge clk); #1;
      new_game_a = 1'b1; move_req_a = 1'b1; row_a = 2'd2; col_a = 2'd2;
      @(posedge clk); #1;
      new_game_a = 1'b0; move_req_a = 1'b0;
      m_valid_a = '0; m_sym_a = '0; m_turn_a = 1'b1; m_cnt_a = 0;
      @(negedge clk);
      n_checks++;
      if ({valid_a, symbol_a, turn_a, cnt_a, gs_a, ack_a, err_a, ready_a, fsm_a} !==
          {{CA{1'b0}}, {CA{1'b0}}, 1'b1, MWA'(0), GS_PLAY, 1'b0, 1'b0, 1'b1, ST_PLAY}) begin
         n_fail++;
         $display("FAIL collision: got v=%h t=%b n=%0d gs=%b ack=%b err=%b rdy=%b, required cleared t=1 rdy=1",
                  valid_a, turn_a, cnt_a, gs_a, ack_a, err_a, ready_a);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid_check();
      new_game_pulse_a();
      exp_q_a.push_back(R_ACK);
      @(posedge clk); #1;
      move_req_a = 1'b1; row_a = 2'd3; col_a = 2'd3;
      @(posedge clk); #1;
      move_req_a = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      n_checks++;
      if (fsm_a !== ST_CHECK) begin
         n_fail++;
         $display("FAIL mid_check_state: got st=%0d, required %0d", fsm_a, ST_CHECK);
      end
      reset_n = 1'b0;
      new_game_a = 1'b1;
      move_req_a = 1'b1; row_a = 2'd1; col_a = 2'd1;
      @(posedge clk); #1;
      reset_n = 1'b1; new_game_a = 1'b0; move_req_a = 1'b0;
      m_valid_a = '0; m_sym_a = '0; m_turn_a = 1'b1; m_cnt_a = 0;
      @(negedge clk);
      n_checks++;
      if ({valid_a, symbol_a, turn_a, cnt_a, gs_a, ack_a, err_a, ready_a, fsm_a} !==
          {{CA{1'b0}}, {CA{1'b0}}, 1'b1, MWA'(0), GS_PLAY, 1'b0, 1'b0, 1'b1, ST_PLAY}) begin
         n_fail++;
         $display("FAIL reset_mid_check: got v=%h t=%b n=%0d gs=%b ack=%b err=%b rdy=%b st=%0d, required cleared t=1 rdy=1 st=0",
                  valid_a, turn_a, cnt_a, gs_a, ack_a, err_a, ready_a, fsm_a);
      end
      n_checks++;
      if (exp_q_a.size() != 0) begin
         n_fail++;
         $display("FAIL reset_pending: got %0d outstanding, required 0", exp_q_a.size());
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_row_win();
      test_occupied();
      test_draw();
      test_anti_diag();
      test_collision();
      test_reset_mid_check();
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
